para_toplama: RTL

//  Upstream stage of the payment block (odeme) in the vending datapath. Accepts coins,

---
 rtl/para_pkg.sv | 24 ++
 rtl/para_toplama_if.sv | 30 +++
 rtl/para_cozucu.sv | 42 ++++
 rtl/para_toplama.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// para_pkg: shared widths, FSM state encoding and helpers for para_toplama.
package para_pkg;

    localparam int PARA_TUR_W = 2;
    localparam int URUN_W     = 2;
    localparam int BAKIYE_W   = 9;
    localparam int UCRET_W    = 8;
    localparam int PARA_W     = 8;
    localparam int TOPLAM_W   = 10;

    typedef enum logic [1:0] {
        BEKLE = 2'd0,
        ODEME = 2'd1,
        SONUC = 2'd2
    } durum_t;

    function automatic logic sigar_mi(
        input logic [TOPLAM_W-1:0] toplam,
        input int unsigned         tavan
    );
        return toplam <= TOPLAM_W'(tavan);
    endfunction

endpackage

// File: rtl/para_toplama_if.sv
// para_toplama_if: start/result handshake between para_toplama and odeme.
interface para_toplama_if;
    import para_pkg::*;

    logic                basla;
    logic [UCRET_W-1:0]  ucret;
    logic [BAKIYE_W-1:0] bakiye;
    logic                onay;
    logic [BAKIYE_W-1:0] k_bakiye;
    logic                bitti;

    modport master (
        output basla,
        output ucret,
        output bakiye,
        input  onay,
        input  k_bakiye,
        input  bitti
    );

    modport slave (
        input  basla,
        input  ucret,
        input  bakiye,
        output onay,
        output k_bakiye,
        output bitti
    );

endinterface

// File: rtl/para_cozucu.sv
// para_cozucu: combinational coin-value and product-price lookup.
module para_cozucu
    import para_pkg::*;
#(
    parameter int PARA0  = 5,
    parameter int PARA1  = 10,
    parameter int PARA2  = 25,
    parameter int PARA3  = 100,
    parameter int FIYAT0 = 25,
    parameter int FIYAT1 = 50,
    parameter int FIYAT2 = 75,
    parameter int FIYAT3 = 120
) (
    input  logic [PARA_TUR_W-1:0] para_tur,
    input  logic [URUN_W-1:0]     urun_no,
    output logic [PARA_W-1:0]     para_deger,
    output logic [UCRET_W-1:0]    fiyat
);

    always_comb begin
        para_deger = '0;
        unique case (para_tur)
            2'd0: para_deger = PARA_W'(PARA0);
            2'd1: para_deger = PARA_W'(PARA1);
            2'd2: para_deger = PARA_W'(PARA2);
            2'd3: para_deger = PARA_W'(PARA3);
            default: para_deger = '0;
        endcase
    end

    always_comb begin
        fiyat = '0;
        unique case (urun_no)
            2'd0: fiyat = UCRET_W'(FIYAT0);
            2'd1: fiyat = UCRET_W'(FIYAT1);
            2'd2: fiyat = UCRET_W'(FIYAT2);
            2'd3: fiyat = UCRET_W'(FIYAT3);
            default: fiyat = '0;
        endcase
    end

endmodule

// File: rtl/para_toplama.sv
// para_toplama: coin balance, product request to odeme, dispense/refund.
// Define ZAMAN_ASIMI_EN to enable the odeme timeout (hata output).
module para_toplama
    import para_pkg::*;
#(
    parameter int PARA0      = 5,
    parameter int PARA1      = 10,
    parameter int PARA2      = 25,
    parameter int PARA3      = 100,
    parameter int FIYAT0     = 25,
    parameter int FIYAT1     = 50,
    parameter int FIYAT2     = 75,
    parameter int FIYAT3     = 120,
    parameter int BAKIYE_MAX = 500
`ifdef ZAMAN_ASIMI_EN
    ,
    parameter int ZAMAN_ASIMI = 15
`endif
) (
    input  logic                  saat,
    input  logic                  reset,
    input  logic                  para_gecerli,
    input  logic [PARA_TUR_W-1:0] para_tur,
    input  logic                  urun_gecerli,
    input  logic [URUN_W-1:0]     urun_no,
    input  logic                  iade,
    para_toplama_if.master        od,
    output logic                  mesgul,
    output logic                  para_red,
    output logic                  urun_ver,
    output logic [URUN_W-1:0]     urun_ver_no,
    output logic                  yetersiz,
    output logic                  iade_gecerli,
    output logic [BAKIYE_W-1:0]   iade_tutar,
    output logic                  hata
);

    durum_t durum, durum_n;

    logic [BAKIYE_W-1:0] kasa, kasa_n;
    logic [URUN_W-1:0]   secim, secim_n;
    logic [UCRET_W-1:0]  ucret_n;
    logic [BAKIYE_W-1:0] bakiye_n;
    logic                basla_n;
    logic                para_red_n;
    logic                urun_ver_n;
    logic [URUN_W-1:0]   urun_ver_no_n;
    logic                yetersiz_n;
    logic                iade_gecerli_n;
    logic [BAKIYE_W-1:0] iade_tutar_n;
    logic                hata_n;

    logic [PARA_W-1:0]   para_deger;
    logic [UCRET_W-1:0]  fiyat;
    logic [TOPLAM_W-1:0] toplam;

`ifdef ZAMAN_ASIMI_EN
    localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);
    logic [SAYAC_W-1:0] sayac, sayac_n;
`endif

    para_cozucu #(
        .PARA0  (PARA0),
        .PARA1  (PARA1),
        .PARA2  (PARA2),
        .PARA3  (PARA3),
        .FIYAT0 (FIYAT0),
        .FIYAT1 (FIYAT1),
        .FIYAT2 (FIYAT2),
        .FIYAT3 (FIYAT3)
    ) u_cozucu (
        .para_tur   (para_tur),
        .urun_no    (urun_no),
        .para_deger (para_deger),
        .fiyat      (fiyat)
    );

    assign toplam = TOPLAM_W'(kasa) + TOPLAM_W'(para_deger);
    assign mesgul = (durum != BEKLE);

    always_comb begin
        durum_n        = durum;
        kasa_n         = kasa;
        secim_n        = secim;
        ucret_n        = od.ucret;
        bakiye_n       = od.bakiye;
        basla_n        = 1'b0;
        para_red_n     = 1'b0;
        urun_ver_n     = 1'b0;
        urun_ver_no_n  = urun_ver_no;
        yetersiz_n     = 1'b0;
        iade_gecerli_n = 1'b0;
        iade_tutar_n   = iade_tutar;
        hata_n         = 1'b0;
`ifdef ZAMAN_ASIMI_EN
        sayac_n        = sayac;
`endif
        unique case (durum)
            BEKLE: begin
                if (urun_gecerli) begin
                    secim_n    = urun_no;
                    ucret_n    = fiyat;
                    bakiye_n   = kasa;
                    basla_n    = 1'b1;
                    para_red_n = para_gecerli;
                    durum_n    = ODEME;
                end else if (iade) begin
                    iade_gecerli_n = 1'b1;
                    iade_tutar_n   = kasa;
                    kasa_n         = '0;
                    para_red_n     = para_gecerli;
                end else if (para_gecerli) begin
                    if (sigar_mi(toplam, BAKIYE_MAX)) begin
                        kasa_n = toplam[BAKIYE_W-1:0];
                    end else begin
                        para_red_n = 1'b1;
                    end
                end
            end
            ODEME: begin
                para_red_n = para_gecerli;
                durum_n    = SONUC;
`ifdef ZAMAN_ASIMI_EN
                sayac_n    = '0;
`endif
            end
            SONUC: begin
                para_red_n = para_gecerli;
                if (od.bitti) begin
                    if (od.onay) begin
                        kasa_n        = od.k_bakiye;
                        urun_ver_n    = 1'b1;
                        urun_ver_no_n = secim;
                    end else begin
                        yetersiz_n = 1'b1;
                    end
                    durum_n = BEKLE;
                end
`ifdef ZAMAN_ASIMI_EN
                else if (sayac == SAYAC_W'(ZAMAN_ASIMI - 1)) begin
                    hata_n  = 1'b1;
                    durum_n = BEKLE;
                end else begin
                    sayac_n = sayac + 1'b1;
                end
`endif
            end
            default: durum_n = BEKLE;
        endcase
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            durum        <= BEKLE;
            kasa         <= '0;
            secim        <= '0;
            od.basla     <= 1'b0;
            od.ucret     <= '0;
            od.bakiye    <= '0;
            para_red     <= 1'b0;
            urun_ver     <= 1'b0;
            urun_ver_no  <= '0;
            yetersiz     <= 1'b0;
            iade_gecerli <= 1'b0;
            iade_tutar   <= '0;
            hata         <= 1'b0;
        end else begin
            durum        <= durum_n;
            kasa         <= kasa_n;
            secim        <= secim_n;
            od.basla     <= basla_n;
            od.ucret     <= ucret_n;
            od.bakiye    <= bakiye_n;
            para_red     <= para_red_n;
            urun_ver     <= urun_ver_n;
            urun_ver_no  <= urun_ver_no_n;
            yetersiz     <= yetersiz_n;
            iade_gecerli <= iade_gecerli_n;
            iade_tutar   <= iade_tutar_n;
            hata         <= hata_n;
        end
    end

`ifdef ZAMAN_ASIMI_EN
    always_ff @(posedge saat) begin
        if (reset) begin
            sayac <= '0;
        end else begin
            sayac <= sayac_n;
        end
    end
`endif

endmodule
